// File: rtl/mems_pkg.sv
// Shared MEMS mirror definitions: DAC frame width, DAC command words and the
// DAC serialiser state encoding used by mems_control, mems_rom and mems_dac_spi.
package mems_pkg;

    localparam int MEMS_DAC_W = 24;

    // 24-bit command words: {cmd[2:0], addr[2:0] in the top byte, 16-bit payload}
    localparam logic [MEMS_DAC_W-1:0] DAC_SW_RESET = 24'h28_0001;
    localparam logic [MEMS_DAC_W-1:0] DAC_VREF_EXT = 24'h38_0000;

    localparam logic [7:0] DAC_WRITE_UPDATE_CH_A = 8'h18;
    localparam logic [7:0] DAC_WRITE_UPDATE_CH_B = 8'h19;
    localparam logic [7:0] DAC_WRITE_UPDATE_CH_C = 8'h1A;
    localparam logic [7:0] DAC_WRITE_UPDATE_CH_D = 8'h1B;

    typedef enum logic [1:0] {
        DAC_IDLE,
        DAC_LOAD,
        DAC_SHIFT,
        DAC_GAP
    } dac_state_t;

    function automatic logic [MEMS_DAC_W-1:0] dac_write_update(input logic [1:0]  ch,
                                                               input logic [15:0] code);
        return {DAC_WRITE_UPDATE_CH_A | {6'b0, ch}, code};
    endfunction

endpackage

// File: rtl/mems_sclk_tick.sv
// SCLK half-period tick generator: pulses tick every CLK_DIV enabled cycles,
// restarting from zero whenever en drops.
module mems_sclk_tick #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int                 CNT_W    = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt <= '0;
        else if (cnt == CNT_LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = en && (cnt == CNT_LAST);

endmodule

// File: rtl/mems_dac_spi.sv
// SPI master for the MEMS mirror DAC: one start serialises one DATA_W-bit word
// MSB-first on sync_n/sclk/mosi, followed by a SYNC_GAP-cycle sync-high gap.
module mems_dac_spi
    import mems_pkg::*;
#(
    parameter int DATA_W   = MEMS_DAC_W,
    parameter int CLK_DIV  = 2,
    parameter int SYNC_GAP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              sync_n,
    output logic              mosi
);

    localparam int               BIT_W    = $clog2(DATA_W + 1);
    localparam int               GAP_W    = $clog2(SYNC_GAP + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);

    dac_state_t        state, state_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_d;
    logic              sclk_d, sync_n_d, mosi_d, busy_d, done_d;
    logic              tick;

    mems_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (state == DAC_SHIFT),
        .tick (tick)
    );

    // NOTE: every signal gets its hold/default value first so no path can infer a latch.
    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
        gap_cnt_d = gap_cnt;
        sclk_d    = sclk;
        sync_n_d  = sync_n;
        mosi_d    = mosi;
        busy_d    = busy;
        done_d    = 1'b0;

        unique case (state)
            DAC_IDLE: begin
                if (start) begin
                    state_d = DAC_LOAD;
                    busy_d  = 1'b1;
                end
            end
            // data_in is taken here, one cycle after start, to cover the ROM read
            DAC_LOAD: begin
                shreg_d   = data_in;
                sync_n_d  = 1'b0;
                sclk_d    = 1'b1;
                mosi_d    = data_in[DATA_W-1];
                bit_cnt_d = '0;
                state_d   = DAC_SHIFT;
            end
            DAC_SHIFT: begin
                if (tick) begin
                    if (sclk) begin
                        sclk_d    = 1'b0;
                        bit_cnt_d = bit_cnt + 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        sclk_d    = 1'b1;
                        sync_n_d  = 1'b1;
                        mosi_d    = 1'b0;
                        bit_cnt_d = '0;
                        gap_cnt_d = '0;
                        state_d   = DAC_GAP;
                    end else begin
                        sclk_d  = 1'b1;
                        shreg_d = shreg << 1;
                        mosi_d  = shreg[DATA_W-2];
                    end
                end
            end
            DAC_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_d = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = DAC_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = DAC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= DAC_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sclk    <= 1'b1;
            sync_n  <= 1'b1;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_d;
            shreg   <= shreg_d;
            bit_cnt <= bit_cnt_d;
            gap_cnt <= gap_cnt_d;
            sclk    <= sclk_d;
            sync_n  <= sync_n_d;
            mosi    <= mosi_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
